binary_div_17_9_seq: RTL

Iterative signed divider that inverts the 9×9 signed multiplier datapath. It takes a 17-bit signed dividend, which can be a product word, and a 9-bit signed divisor. It returns a 17-bit signed quotient and a 9-bit signed remainder using one restoring-division step per clock. The block sits beside the multiplier in the arithmetic cluster and uses a start/busy/done handshake so a sequencer can issue divides back-to-back.

---
 rtl/binary_div_17_9_seq_pkg.sv | 28 ++
 rtl/binary_div_17_9_seq_if.sv | 31 +++
 rtl/binary_div_17_9_seq_step.sv | 23 ++
 rtl/binary_div_17_9_seq.sv | 119 +++++++++++
 4 files changed

// File: rtl/binary_div_17_9_seq_pkg.sv
// Shared arithmetic definitions for the 17/9 signed sequential divider:
// FSM states, datapath widths, forced-result constants and magnitude helpers.
package binary_div_17_9_seq_pkg;

  localparam int DW  = 17;
  localparam int VW  = 9;
  localparam int PRW = VW + 1;

  localparam logic [DW-1:0] QZERO_FILL = 17'h1FFFF;
  localparam logic [DW-1:0] QOVF       = 17'h10000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's-complement magnitude; the most negative value maps to its unsigned
  // magnitude (e.g. -65536 -> 17'h10000, -256 -> 9'h100).
  function automatic logic [DW-1:0] mag_n(input logic [DW-1:0] x);
    return x[DW-1] ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [VW-1:0] mag_d(input logic [VW-1:0] x);
    return x[VW-1] ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/binary_div_17_9_seq_if.sv
// Request/result bundle between a sequencer (master) and the divider (slave).
interface binary_div_17_9_seq_if;
  import binary_div_17_9_seq_pkg::*;

  // Handshake: start is sampled on a rising edge only while the divider is
  // IDLE or DONE; N and D are captured in that same edge. busy is high for
  // the whole computation and start is ignored then. done pulses for one
  // cycle; Q, R, div_zero and ovf are valid from it and hold until the next
  // done. A start during done is accepted, giving back-to-back operation.
  logic          start;
  logic [DW-1:0] N;
  logic [VW-1:0] D;
  logic [DW-1:0] Q;
  logic [VW-1:0] R;
  logic          busy;
  logic          done;
  logic          div_zero;
  logic          ovf;
  state_t        state;

  modport master (
    output start, N, D,
    input  Q, R, busy, done, div_zero, ovf, state
  );

  modport slave (
    input  start, N, D,
    output Q, R, busy, done, div_zero, ovf, state
  );

endinterface

// File: rtl/binary_div_17_9_seq_step.sv
// One restoring-division step: shift in a dividend bit, then subtract the
// divisor magnitude if it fits.
module binary_div_17_9_seq_step
  import binary_div_17_9_seq_pkg::*;
(
  input  logic [PRW-1:0] pr,
  input  logic           in_bit,
  input  logic [VW-1:0]  dmag,
  output logic [PRW-1:0] pr_nxt,
  output logic           q_bit
);

  logic [PRW-1:0] trial;

  // pr stays below |D| <= 256, so dropping its top bit in the shift is
  // lossless; the full-width compare keeps the divide-by-zero case defined.
  always_comb begin
    trial  = {pr[VW-1:0], in_bit};
    q_bit  = ({pr, in_bit} >= {2'b00, dmag});
    pr_nxt = q_bit ? (trial - {1'b0, dmag}) : trial;
  end

endmodule

// File: rtl/binary_div_17_9_seq.sv
// Iterative signed divider, 17-bit dividend by 9-bit divisor, one restoring
// step per clock; quotient truncates toward zero, remainder takes N's sign.
module binary_div_17_9_seq
  import binary_div_17_9_seq_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  binary_div_17_9_seq_if.slave          bus
);

  state_t         state, state_nxt;
  logic [4:0]     cnt;
  logic [DW-1:0]  acc;
  logic [PRW-1:0] pr, pr_nxt;
  logic [VW-1:0]  dmag;
  logic           sn, sd, dz;
  logic           q_bit;
  logic           accept;

  logic [DW-1:0]  q_reg;
  logic [VW-1:0]  r_reg;
  logic           dz_reg, ovf_reg;

  logic [DW-1:0]  qmag_fin, q_fix;
  logic [VW-1:0]  rmag_fin, r_fix;
  logic           q_neg, ovf_fin;

  binary_div_17_9_seq_step u_step (
    .pr     (pr),
    .in_bit (acc[DW-1]),
    .dmag   (dmag),
    .pr_nxt (pr_nxt),
    .q_bit  (q_bit)
  );

  assign accept = bus.start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CALC;
      CALC:    if (cnt == 5'd0) state_nxt = DONE;
      DONE:    state_nxt = bus.start ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Result of the final step, including the bit produced in this cycle.
  always_comb begin
    qmag_fin = {acc[DW-2:0], q_bit};
    rmag_fin = pr_nxt[VW-1:0];
    q_neg    = sn ^ sd;
    q_fix    = q_neg ? (~qmag_fin + 1'b1) : qmag_fin;
    r_fix    = sn ? (~rmag_fin + 1'b1) : rmag_fin;
    ovf_fin  = !q_neg && qmag_fin[DW-1];
  end

  // The dividend shift register doubles as the quotient register: each step
  // pops the dividend MSB and pushes the new quotient bit in at the LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      pr      <= '0;
      dmag    <= '0;
      sn      <= 1'b0;
      sd      <= 1'b0;
      dz      <= 1'b0;
      cnt     <= '0;
      q_reg   <= '0;
      r_reg   <= '0;
      dz_reg  <= 1'b0;
      ovf_reg <= 1'b0;
    end else if (accept) begin
      sn   <= bus.N[DW-1];
      sd   <= bus.D[VW-1];
      acc  <= mag_n(bus.N);
      dmag <= mag_d(bus.D);
      dz   <= (bus.D == '0);
      cnt  <= 5'd16;
      pr   <= '0;
    end else if (state == CALC) begin
      acc <= {acc[DW-2:0], q_bit};
      pr  <= pr_nxt;
      cnt <= cnt - 5'd1;
      if (cnt == 5'd0) begin
        if (dz) begin
          q_reg   <= QZERO_FILL;
          r_reg   <= '0;
          dz_reg  <= 1'b1;
          ovf_reg <= 1'b0;
        end else if (ovf_fin) begin
          q_reg   <= QOVF;
          r_reg   <= '0;
          dz_reg  <= 1'b0;
          ovf_reg <= 1'b1;
        end else begin
          q_reg   <= q_fix;
          r_reg   <= r_fix;
          dz_reg  <= 1'b0;
          ovf_reg <= 1'b0;
        end
      end
    end
  end

  assign bus.Q        = q_reg;
  assign bus.R        = r_reg;
  assign bus.div_zero = dz_reg;
  assign bus.ovf      = ovf_reg;
  assign bus.busy     = (state == CALC);
  assign bus.done     = (state == DONE);
  assign bus.state    = state;

endmodule
